// File: rtl/signed_conv_pipe_pkg.sv
// Shared types and width constants for the signed TC/SM conversion pipeline.
// No logic; imported by the core and the pipeline top.
// Not applicable (package only).
package signed_conv_pipe_pkg;

    typedef enum logic {
        MODE_TC2SM = 1'b0,
        MODE_SM2TC = 1'b1
    } conv_mode_e;

    localparam int DW_DEFAULT        = 16;
    localparam int DW_MIN            = 4;
    localparam int DW_MAX            = 32;
    localparam int OVF_CNT_W_DEFAULT = 8;

endpackage

// File: rtl/signed_conv_core.sv
// Combinational TC<->SM converter with most-negative saturation and negative-zero folding.
// Latency: zero (pure combinational).
// No flow control; the enclosing pipeline owns the handshake.
module signed_conv_core
    import signed_conv_pipe_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  conv_mode_e      mode,
    input  logic            sign_a,
    input  logic            sign_b,
    input  logic [DW-1:0]   data,
    output logic            res_sign,
    output logic [DW-1:0]   res_data,
    output logic            res_ovf
);

    localparam logic [DW-1:0] ONE      = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [DW-2:0] ONE_LO   = {{(DW-2){1'b0}}, 1'b1};
    localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

    logic [DW-2:0] neg_lo;
    logic [DW-2:0] mag_lo;
    logic [DW-1:0] mag_sm;
    logic [DW-1:0] neg_sm;
    logic          sm_sign;

    // Low DW-1 bits of the DW-wide negation; the sign bit of the magnitude is always 0.
    assign neg_lo  = ~data[DW-2:0] + ONE_LO;
    assign mag_lo  = data[DW-1] ? neg_lo : data[DW-2:0];
    assign mag_sm  = {1'b0, data[DW-2:0]};
    assign neg_sm  = ~mag_sm + ONE;
    assign sm_sign = sign_a ^ sign_b;

    always_comb begin
        res_sign = 1'b0;
        res_data = '0;
        res_ovf  = 1'b0;
        case (mode)
            MODE_TC2SM: begin
                if (data == MOST_NEG) begin
                    res_sign = 1'b1;
                    res_data = {1'b0, {(DW-1){1'b1}}};
                    res_ovf  = 1'b1;
                end else begin
                    res_sign = data[DW-1];
                    res_data = {1'b0, mag_lo};
                end
            end
            MODE_SM2TC: begin
                // Negative zero collapses to +0.
                if (mag_sm != '0) begin
                    res_sign = sm_sign;
                    res_data = sm_sign ? neg_sm : mag_sm;
                end
            end
            default: begin
                res_sign = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/signed_conv_pipe.sv
// Two-stage valid/ready pipeline around signed_conv_core plus a saturating overflow event counter.
// Latency: 2 cycles acceptance to out_valid; 1 result per cycle with out_ready held high.
// Backpressure: out_ready low freezes S2, S1 then fills and in_ready drops combinationally.
module signed_conv_pipe
    import signed_conv_pipe_pkg::*;
#(
    parameter int DW        = DW_DEFAULT,
    parameter int OVF_CNT_W = OVF_CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic                 in_sign_a,
    input  logic                 in_sign_b,
    input  logic [DW-1:0]        in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sign,
    output logic [DW-1:0]        out_data,
    output logic                 out_ovf,
    input  logic                 ovf_clr,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    localparam logic [OVF_CNT_W-1:0] CNT_MAX = {OVF_CNT_W{1'b1}};
    localparam logic [OVF_CNT_W-1:0] CNT_ONE = {{(OVF_CNT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic            valid;
        conv_mode_e      mode;
        logic            sign_a;
        logic            sign_b;
        logic [DW-1:0]   data;
    } capt_t;

    typedef struct packed {
        logic            valid;
        logic            sign;
        logic [DW-1:0]   data;
        logic            ovf;
    } stage_t;

    capt_t                s1;
    stage_t               s2;
    logic                 s1_adv;
    logic                 s2_adv;
    logic                 out_hs;
    logic                 core_sign;
    logic [DW-1:0]        core_data;
    logic                 core_ovf;
    logic [OVF_CNT_W-1:0] ovf_cnt_q;

    assign s2_adv   = !s2.valid || out_ready;
    assign s1_adv   = !s1.valid || s2_adv;
    assign in_ready = s1_adv;
    assign out_hs   = s2.valid && out_ready;

    // Payload registers only load on a real transfer so idle inputs never leak in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
        end else if (s1_adv) begin
            s1.valid <= in_valid;
            if (in_valid) begin
                s1.mode   <= conv_mode_e'(in_mode);
                s1.sign_a <= in_sign_a;
                s1.sign_b <= in_sign_b;
                s1.data   <= in_data;
            end
        end
    end

    signed_conv_core #(
        .DW (DW)
    ) u_core (
        .mode     (s1.mode),
        .sign_a   (s1.sign_a),
        .sign_b   (s1.sign_b),
        .data     (s1.data),
        .res_sign (core_sign),
        .res_data (core_data),
        .res_ovf  (core_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2 <= '0;
        end else if (s2_adv) begin
            s2.valid <= s1.valid;
            if (s1.valid) begin
                s2.sign <= core_sign;
                s2.data <= core_data;
                s2.ovf  <= core_ovf;
            end
        end
    end

    // Clear has priority over a coincident counted handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_cnt_q <= '0;
        end else if (ovf_clr) begin
            ovf_cnt_q <= '0;
        end else if (out_hs && s2.ovf && (ovf_cnt_q != CNT_MAX)) begin
            ovf_cnt_q <= ovf_cnt_q + CNT_ONE;
        end
    end

    assign out_valid = s2.valid;
    assign out_sign  = s2.sign;
    assign out_data  = s2.data;
    assign out_ovf   = s2.ovf;
    assign ovf_count = ovf_cnt_q;

endmodule

// File: tb/tb_signed_conv_pipe.sv
// Directed bench for signed_conv_pipe (DW=16, OVF_CNT_W=2) with a queue-based reference model.
module tb_signed_conv_pipe;

    localparam int DW   = 16;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_mode = 1'b0;
    logic          in_sign_a = 1'b0;
    logic          in_sign_b = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_sign;
    logic [DW-1:0] out_data;
    logic          out_ovf;
    logic          ovf_clr = 1'b0;
    logic [CW-1:0] ovf_count;

    signed_conv_pipe #(.DW(DW), .OVF_CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_sign_a (in_sign_a),
        .in_sign_b (in_sign_b),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .ovf_clr   (ovf_clr),
        .ovf_count (ovf_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          s;
        bit [DW-1:0] d;
        bit          o;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_cnt  = 0;
    int   out_cnt = 0;

    bit          vm [8];
    bit          va [8];
    bit          vb [8];
    bit [DW-1:0] vd [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: interpret the value as a signed integer and re-encode it.
    function automatic exp_t model(input bit mode, input bit a, input bit b, input bit [DW-1:0] d);
        exp_t e;
        int   v;
        int   mag;
        int   m;
        e.s = 1'b0; e.d = '0; e.o = 1'b0;
        if (!mode) begin
            v   = d[DW-1] ? (int'(d) - (1 << DW)) : int'(d);
            mag = (v < 0) ? -v : v;
            e.s = (v < 0);
            if (mag > (1 << (DW-1)) - 1) begin
                e.d = DW'((1 << (DW-1)) - 1);
                e.o = 1'b1;
            end else begin
                e.d = DW'(mag);
            end
        end else begin
            m   = int'(d) % (1 << (DW-1));
            e.s = (a ^ b) && (m != 0);
            e.d = e.s ? DW'((1 << DW) - m) : DW'(m);
        end
        return e;
    endfunction

    always @(negedge clk) begin : compare
        exp_t e;
        bit   hs_ovf;
        hs_ovf = 1'b0;
        if (!rst) begin
            q.delete();
            m_cnt = 0;
        end else begin
            chk("ovf_count_model", 32'(ovf_count), 32'(m_cnt));
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("out_unexpected", {31'b0, out_valid}, 32'd0);
                end else begin
                    e = q[0];
                    chk("out_sign_model", {31'b0, out_sign}, {31'b0, e.s});
                    chk("out_data_model", 32'(out_data), 32'(e.d));
                    chk("out_ovf_model",  {31'b0, out_ovf},  {31'b0, e.o});
                    if (out_ready) begin
                        void'(q.pop_front());
                        out_cnt++;
                        hs_ovf = e.o;
                    end
                end
            end
            if (ovf_clr) m_cnt = 0;
            else if (hs_ovf && m_cnt != CMAX) m_cnt = m_cnt + 1;
            if (in_valid && in_ready) q.push_back(model(in_mode, in_sign_a, in_sign_b, in_data));
        end
    end

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    // Present one transaction and return just after the edge that accepted it.
    task automatic send(input bit mode, input bit a, input bit b, input bit [DW-1:0] d);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1; in_mode = mode; in_sign_a = a; in_sign_b = b; in_data = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (n >= 50) chk("send_timeout", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic dir(input string name, input bit mode, input bit a, input bit b,
                       input bit [DW-1:0] d, input bit es, input bit [DW-1:0] ed, input bit eo);
        out_ready = 1'b1;
        send(mode, a, b, d);
        @(negedge clk);
        chk({name, "_lat1"}, {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        chk({name, "_valid"}, {31'b0, out_valid}, 32'd1);
        chk({name, "_sign"},  {31'b0, out_sign},  {31'b0, es});
        chk({name, "_data"},  32'(out_data),      32'(ed));
        chk({name, "_ovf"},   {31'b0, out_ovf},   {31'b0, eo});
        @(posedge clk); #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(q.size()), 32'd0);
    endtask

    // Stream n entries of vm/va/vb/vd; out_ready stays low for the first `stall` cycles.
    task automatic stream(input int n, input int stall, output int early);
        int idx;
        bit acc;
        idx = 0; early = 0;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b1; in_mode = vm[0]; in_sign_a = va[0]; in_sign_b = vb[0]; in_data = vd[0];
        for (int cyc = 0; cyc < 200 && idx < n; cyc++) begin
            @(negedge clk);
            acc = in_ready;
            if (stall > 0 && cyc == stall - 1) chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
            if (acc && cyc < stall) early++;
            @(posedge clk); #1;
            if (cyc == stall - 1) out_ready = 1'b1;
            if (acc) begin
                idx++;
                if (idx < n) begin
                    in_mode = vm[idx]; in_sign_a = va[idx]; in_sign_b = vb[idx]; in_data = vd[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        chk("stream_all_accepted", 32'(idx), 32'(n));
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : main
        int early;
        int base;

        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data",  32'(out_data),      32'd0);
        chk("rst_ovf_count", 32'(ovf_count),     32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("idle_in_ready",  {31'b0, in_ready},  32'd1);
        chk("idle_out_valid", {31'b0, out_valid}, 32'd0);

        dir("tc_fffb",  1'b0, 1'b0, 1'b0, 16'hFFFB, 1'b1, 16'h0005, 1'b0);
        dir("tc_0007",  1'b0, 1'b0, 1'b0, 16'h0007, 1'b0, 16'h0007, 1'b0);
        dir("tc_7fff",  1'b0, 1'b0, 1'b0, 16'h7FFF, 1'b0, 16'h7FFF, 1'b0);
        dir("tc_8001",  1'b0, 1'b0, 1'b0, 16'h8001, 1'b1, 16'h7FFF, 1'b0);
        dir("tc_8000",  1'b0, 1'b0, 1'b0, 16'h8000, 1'b1, 16'h7FFF, 1'b1);
        @(negedge clk);
        chk("tc_8000_count", 32'(ovf_count), 32'd1);
        dir("sm_neg5",  1'b1, 1'b1, 1'b0, 16'h0005, 1'b1, 16'hFFFB, 1'b0);
        dir("sm_pos5",  1'b1, 1'b1, 1'b1, 16'h0005, 1'b0, 16'h0005, 1'b0);
        dir("sm_negz",  1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        dir("sm_msbig", 1'b1, 1'b0, 1'b1, 16'h8003, 1'b1, 16'hFFFD, 1'b0);

        // Backpressure: 8 mixed transactions, out_ready low for 5 cycles.
        for (int i = 0; i < 8; i++) begin
            vm[i] = i[0];
            va[i] = i[1];
            vb[i] = i[2];
            vd[i] = 16'(16'hFFF0 - 16'(i * 1234));
        end
        base = out_cnt;
        stream(8, 5, early);
        chk("bp_early_accepts", 32'(early), 32'd2);
        drain("bp_drain");
        chk("bp_out_count", 32'(out_cnt - base), 32'd8);

        // Counter saturation from zero.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            vm[i] = 1'b0; va[i] = 1'b0; vb[i] = 1'b0; vd[i] = 16'h8000;
        end
        stream(5, 0, early);
        drain("sat_drain");
        @(negedge clk);
        chk("sat_count", 32'(ovf_count), 32'd3);

        // Clear coincident with a counted overflow handshake.
        out_ready = 1'b1;
        send(1'b0, 1'b0, 1'b0, 16'h8000);
        @(posedge clk); #1;
        ovf_clr = 1'b1;
        @(negedge clk);
        chk("clr_hs_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("clr_wins", 32'(ovf_count), 32'd0);

        // Reset in the middle of a stream.
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_mode = 1'b0; in_data = 16'hFFFD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("rst_drops_valid", {31'b0, out_valid}, 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("post_rst_count",     32'(ovf_count),     32'd0);
        repeat (3) @(negedge clk);
        chk("post_rst_no_ghost", {31'b0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/signed_conv_pipe.md
Name: signed_conv_pipe

Overview:
- Parametrised, pipelined successor of the multiplier-result sign converter.
- Converts between two's complement (TC) and sign-magnitude (SM) in either direction, selected per transaction.
- Valid/ready streaming handshake, overflow detection with saturation, and a saturating overflow event counter.
- Sits between the sequential multiplier core and the display/BCD path of P01; also reusable on operand inputs.

Parameters:
- DW, 16: data width in bits, including the sign position; legal range 4..32.
- OVF_CNT_W, 8: width of the overflow event counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept an input this cycle.
- in_mode  in  1  0 = TC->SM, 1 = SM->TC.
- in_sign_a  in  1  SM->TC only: operand A sign.
- in_sign_b  in  1  SM->TC only: operand B sign.
- in_data  in  DW  TC value (TC->SM), or magnitude in [DW-2:0] (SM->TC).
- out_valid  out  1  output transaction valid.
- out_ready  in  1  downstream accepts the output.
- out_sign  out  1  sign of the result.
- out_data  out  DW  converted value.
- out_ovf  out  1  result saturated.
- ovf_clr  in  1  synchronous clear of ovf_count.
- ovf_count  out  OVF_CNT_W  saturating count of accepted overflow results.

Behaviour:
- Reset (rst=0, asynchronous):
  - Stage valids, out_valid, out_sign, out_data, out_ovf and ovf_count all go to 0.
  - in_ready is 1 on the first cycle after reset release.
- Handshake:
  - An input is accepted when in_valid and in_ready are both 1.
  - The output is consumed when out_valid and out_ready are both 1.
  - in_data, in_mode and the sign inputs are sampled only at acceptance.
  - While out_valid=1 and out_ready=0, the outputs hold stable.
- Pipeline: two register stages, S1 (capture and decode) and S2 (output).
  - S2 advances when !S2.valid || out_ready.
  - S1 advances when !S1.valid || S2 advances.
  - in_ready equals the S1 advance condition, derived combinationally.
  - Latency is 2 cycles from acceptance to out_valid.
  - Throughput is 1 per cycle under continuous out_ready, with no bubbles.
  - Under backpressure, S1 and S2 both fill, then in_ready drops.
  - Ordering is preserved; nothing is dropped or duplicated.
- TC->SM (mode 0):
  - s = in_data[DW-1]; mag = s ? (~in_data + 1) : in_data.
  - out_sign = s; out_data = {1'b0, mag[DW-2:0]}.
  - If in_data = 2^(DW-1) (most negative value): out_data = {1'b0, all ones}, out_sign = 1, out_ovf = 1.
- SM->TC (mode 1):
  - s = in_sign_a ^ in_sign_b; m = in_data[DW-2:0]; in_data[DW-1] is ignored.
  - out_data = s ? ~{1'b0, m} + 1 : {1'b0, m}; out_sign = s; out_ovf = 0.
  - Negative zero (s=1, m=0) gives out_data = 0 and out_sign = 0.
- Arithmetic:
  - Negation is computed DW bits wide; the carry-out is discarded.
  - No X propagates from unused bits.
- Overflow counter:
  - Increments by 1 on each output handshake with out_ovf=1.
  - Saturates at 2^OVF_CNT_W - 1.
  - If ovf_clr coincides with a counted handshake, ovf_clr wins and the count becomes 0.
- Reset mid-operation: in-flight transactions are discarded and no partial output appears.

Decomposition:
- Pkg_Global additions:
  - typedef enum logic {MODE_TC2SM = 1'b0, MODE_SM2TC = 1'b1} conv_mode_e.
  - Width constants used by the block.
- Pkg_SignedConv: packed struct stage_t {valid, sign, data[DW], ovf} for S1/S2 payloads.
- One combinational sub-module, signed_conv_core:
  - Inputs: mode, sign_a, sign_b, data.
  - Outputs: sign, data, ovf.
  - Instantiated between S1 and S2 so it can be unit-tested alone.

Test Plan:
- Reset then idle:
  - Release rst -> in_ready=1, out_valid=0, ovf_count=0.
  - Assert rst mid-stream -> out_valid drops the same cycle.
- TC->SM, DW=16:
  - in_data=16'hFFFB -> 2 cycles later out_sign=1, out_data=16'h0005, out_ovf=0.
  - in_data=16'h0007 -> out_sign=0, out_data=16'h0007.
- Most negative, DW=16: in_data=16'h8000, mode 0 -> out_data=16'h7FFF, out_sign=1, out_ovf=1, ovf_count=1.
- SM->TC signs, DW=16:
  - sign_a=1, sign_b=0, in_data=16'h0005 -> out_data=16'hFFFB, out_sign=1.
  - sign_a=1, sign_b=1 -> out_data=16'h0005, out_sign=0.
  - Negative zero (s=1, m=0) -> out_data=16'h0000, out_sign=0.
- Backpressure:
  - Stream 8 values with out_ready=0 for 5 cycles -> in_ready falls after 2 accepts; outputs hold.
  - After out_ready returns, all 8 results emerge in order with none lost.
- Counter saturation and clear:
  - OVF_CNT_W=2, five 16'h8000 inputs -> ovf_count stops at 3.
  - ovf_clr asserted together with a counted overflow -> ovf_count=0.
